// File: rtl/pio_channel_sequencer.sv
// Sequences one PIO transfer: decodes the latched address to a channel select.
// Then it issues a write strobe or waits, with a timeout, for a read acknowledge.
//
// Handshake: a transfer is accepted only in IDLE on W7 with PIOD high.
// PIOD must stay high until the sequence reaches DONE; dropping it earlier aborts.
// Read data is valid in RDATA during the single cycle that RDV is high, and RDATA holds afterwards.
module pio_channel_sequencer #(
  parameter logic [3:0] ACK_TIMEOUT = 4'd15
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        A1D,
  input  logic        A2D,
  input  logic        A3D,
  input  logic        A4D,
  input  logic        A5D,
  input  logic        A6D,
  input  logic        A7D,
  input  logic        A8D,
  input  logic        A9D,
  input  logic        PIOD,
  input  logic        DINF,
  input  logic        W7,
  input  logic        Z7,
  input  logic        PACK,
  input  logic [25:0] PDATA,
  output logic [15:0] CHSEL,
  output logic        DOUT_STB,
  output logic [25:0] RDATA,
  output logic        RDV,
  output logic        ERR,
  output logic        BUSY,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SELECT   = 3'd1;
  localparam logic [2:0] STROBE   = 3'd2;
  localparam logic [2:0] WAIT_ACK = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [2:0] ABORT    = 3'd5;

  logic [2:0] state;
  logic [8:0] addr;
  logic       dinf_q;
  logic [3:0] cnt;

  assign BUSY      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state    <= IDLE;
      addr     <= 9'd0;
      dinf_q   <= 1'b0;
      cnt      <= 4'd0;
      CHSEL    <= 16'd0;
      DOUT_STB <= 1'b0;
      RDATA    <= 26'd0;
      RDV      <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      DOUT_STB <= 1'b0;
      RDV      <= 1'b0;
      case (state)
        IDLE: begin
          if (W7 && PIOD) begin
            addr   <= {A9D, A8D, A7D, A6D, A5D, A4D, A3D, A2D, A1D};
            dinf_q <= DINF;
            ERR    <= 1'b0;
            state  <= SELECT;
          end
        end
        SELECT: begin
          if (!PIOD) begin
            CHSEL <= 16'd0;
            ERR   <= 1'b1;
            state <= ABORT;
          end else if (addr[8:4] == 5'd0) begin
            CHSEL <= 16'd1 << addr[3:0];
            state <= STROBE;
          end else begin
            // Only 16 channels exist; any upper address bit is a decode error.
            CHSEL <= 16'd0;
            ERR   <= 1'b1;
            state <= DONE;
          end
        end
        STROBE: begin
          if (!PIOD) begin
            CHSEL <= 16'd0;
            ERR   <= 1'b1;
            state <= ABORT;
          end else if (!dinf_q) begin
            DOUT_STB <= 1'b1;
            CHSEL    <= 16'd0;
            state    <= DONE;
          end else begin
            cnt   <= 4'd0;
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!PIOD) begin
            CHSEL <= 16'd0;
            ERR   <= 1'b1;
            state <= ABORT;
          end else if (PACK) begin
            // Acknowledge wins even on the cycle the timeout would expire.
            RDATA <= PDATA;
            RDV   <= 1'b1;
            CHSEL <= 16'd0;
            state <= DONE;
          end else if (cnt + 4'd1 == ACK_TIMEOUT) begin
            ERR   <= 1'b1;
            RDATA <= 26'd0;
            CHSEL <= 16'd0;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (Z7) state <= IDLE;
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          CHSEL <= 16'd0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_channel_sequencer.sv
// Directed bench for pio_channel_sequencer: write, read, timeout, ack-at-limit,
// bad address, abort and mid-read reset, checked with immediate assertions.
module tb_pio_channel_sequencer;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_STROBE   = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ABORT    = 3'd5;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST;
  logic        A1D, A2D, A3D, A4D, A5D, A6D, A7D, A8D, A9D;
  logic        PIOD, DINF, W7, Z7, PACK;
  logic [25:0] PDATA;
  logic [15:0] CHSEL;
  logic        DOUT_STB;
  logic [25:0] RDATA;
  logic        RDV, ERR, BUSY;
  logic [2:0]  state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  pio_channel_sequencer dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
    .A1D(A1D), .A2D(A2D), .A3D(A3D), .A4D(A4D), .A5D(A5D),
    .A6D(A6D), .A7D(A7D), .A8D(A8D), .A9D(A9D),
    .PIOD(PIOD), .DINF(DINF), .W7(W7), .Z7(Z7), .PACK(PACK), .PDATA(PDATA),
    .CHSEL(CHSEL), .DOUT_STB(DOUT_STB), .RDATA(RDATA), .RDV(RDV),
    .ERR(ERR), .BUSY(BUSY), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 SIM_CLK = ~SIM_CLK;

  task automatic step();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input logic [8:0] a);
    {A9D, A8D, A7D, A6D, A5D, A4D, A3D, A2D, A1D} = a;
  endtask

  // Start a transfer; returns with the DUT just past the accepting edge.
  task automatic start(input logic [8:0] a, input logic rd);
    set_addr(a);
    DINF = rd;
    PIOD = 1'b1;
    W7   = 1'b1;
    step();
    W7 = 1'b0;
  endtask

  task automatic finish_done();
    Z7 = 1'b1;
    PIOD = 1'b0;
    step();
    Z7 = 1'b0;
  endtask

  initial begin
    SIM_RST = 1'b1;
    set_addr(9'd0);
    PIOD = 0; DINF = 0; W7 = 0; Z7 = 0; PACK = 0; PDATA = 26'd0;
    step();
    step();
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_chsel", 32'(CHSEL), 32'h0);
    chk("rst_rdata", 32'(RDATA), 32'h0);
    chk("rst_flags", {28'd0, DOUT_STB, RDV, ERR, BUSY}, 32'h0);
    SIM_RST = 1'b0;
    step();

    // ---- write to channel 5 ----
    start(9'h005, 1'b0);
    chk("wr_select", 32'(state_dbg), 32'(S_SELECT));
    chk("wr_busy", 32'(BUSY), 32'h1);
    chk("wr_n0_chsel", 32'(CHSEL), 32'h0);
    step();
    chk("wr_n1_chsel", 32'(CHSEL), 32'h0020);
    chk("wr_n1_stb", 32'(DOUT_STB), 32'h0);
    W7 = 1'b1;
    step();
    chk("wr_n2_stb", 32'(DOUT_STB), 32'h1);
    chk("wr_n2_chsel", 32'(CHSEL), 32'h0);
    chk("wr_n2_state", 32'(state_dbg), 32'(S_DONE));
    PIOD = 1'b0;
    step();
    W7 = 1'b0;
    chk("wr_n3_stb", 32'(DOUT_STB), 32'h0);
    chk("wr_done_hold", 32'(state_dbg), 32'(S_DONE));
    chk("wr_err", 32'(ERR), 32'h0);
    finish_done();
    chk("wr_idle", 32'(state_dbg), 32'(S_IDLE));
    chk("wr_idle_busy", 32'(BUSY), 32'h0);

    // ---- read from channel 15, ack 3 cycles into WAIT_ACK ----
    start(9'h00F, 1'b1);
    step();
    chk("rd_chsel", 32'(CHSEL), 32'h8000);
    step();
    chk("rd_wait", 32'(state_dbg), 32'(S_WAIT_ACK));
    chk("rd_no_stb", 32'(DOUT_STB), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rd_wait_rdv", 32'(RDV), 32'h0);
    end
    PACK = 1'b1;
    PDATA = 26'h2AAAAAA;
    step();
    PACK = 1'b0;
    chk("rd_rdata", 32'(RDATA), 32'h2AAAAAA);
    chk("rd_rdv", 32'(RDV), 32'h1);
    chk("rd_err", 32'(ERR), 32'h0);
    chk("rd_done_chsel", 32'(CHSEL), 32'h0);
    PACK = 1'b1;
    PDATA = 26'h0000123;
    step();
    PACK = 1'b0;
    chk("rd_rdv_once", 32'(RDV), 32'h0);
    chk("rd_pack_ignored", 32'(RDATA), 32'h2AAAAAA);
    finish_done();

    // ---- read timeout ----
    start(9'h003, 1'b1);
    step();
    step();
    for (int i = 0; i < 14; i++) begin
      step();
      chk("to_still_wait", 32'(state_dbg), 32'(S_WAIT_ACK));
    end
    step();
    chk("to_state", 32'(state_dbg), 32'(S_DONE));
    chk("to_err", 32'(ERR), 32'h1);
    chk("to_rdata", 32'(RDATA), 32'h0);
    chk("to_rdv", 32'(RDV), 32'h0);
    finish_done();
    chk("to_err_sticky", 32'(ERR), 32'h1);

    // ---- ack on the timeout edge counts as ack ----
    start(9'h001, 1'b1);
    chk("lim_err_clear", 32'(ERR), 32'h0);
    step();
    step();
    for (int i = 0; i < 14; i++) step();
    PACK = 1'b1;
    PDATA = 26'h1234567;
    step();
    PACK = 1'b0;
    chk("lim_err", 32'(ERR), 32'h0);
    chk("lim_rdata", 32'(RDATA), 32'h1234567);
    chk("lim_rdv", 32'(RDV), 32'h1);
    finish_done();

    // ---- bad address ----
    start(9'h010, 1'b0);
    step();
    chk("bad_state", 32'(state_dbg), 32'(S_DONE));
    chk("bad_err", 32'(ERR), 32'h1);
    chk("bad_chsel", 32'(CHSEL), 32'h0);
    step();
    chk("bad_stb", 32'(DOUT_STB), 32'h0);
    chk("bad_chsel2", 32'(CHSEL), 32'h0);
    finish_done();

    // ---- abort from WAIT_ACK ----
    start(9'h002, 1'b1);
    step();
    step();
    chk("ab_chsel_pre", 32'(CHSEL), 32'h0004);
    PIOD = 1'b0;
    step();
    chk("ab_state", 32'(state_dbg), 32'(S_ABORT));
    chk("ab_chsel", 32'(CHSEL), 32'h0);
    chk("ab_err", 32'(ERR), 32'h1);
    chk("ab_rdv", 32'(RDV), 32'h0);
    step();
    chk("ab_idle", 32'(state_dbg), 32'(S_IDLE));

    // ---- reset in the middle of a read ----
    start(9'h004, 1'b1);
    step();
    step();
    chk("rr_wait", 32'(state_dbg), 32'(S_WAIT_ACK));
    chk("rr_chsel_pre", 32'(CHSEL), 32'h0010);
    #3;
    SIM_RST = 1'b1;
    #1;
    chk("rr_async_chsel", 32'(CHSEL), 32'h0);
    chk("rr_async_rdata", 32'(RDATA), 32'h0);
    chk("rr_async_flags", {28'd0, DOUT_STB, RDV, ERR, BUSY}, 32'h0);
    chk("rr_async_state", 32'(state_dbg), 32'(S_IDLE));
    PACK = 1'b1;
    step();
    SIM_RST = 1'b0;
    step();
    chk("rr_no_rdv", 32'(RDV), 32'h0);
    step();
    chk("rr_no_rdv2", 32'(RDV), 32'h0);
    chk("rr_idle", 32'(state_dbg), 32'(S_IDLE));
    PACK = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_channel_sequencer.md
PIO_CHANNEL_SEQUENCER -- requirements
Module: pio_channel_sequencer

Interface
REQ-001 SHALL have port SIM_CLK, input, 1: the single block clock; all state updates on its rising edge.
REQ-002 SHALL have port SIM_RST, input, 1: reset, asynchronous and active-high.
REQ-003 SHALL have ports A1D..A9D, input, 1 each: latched PIO address bits; A1D is the LSB.
REQ-004 SHALL have port PIOD, input, 1: PIO operation in progress (level).
REQ-005 SHALL have port DINF, input, 1: 1 means a data-input (read) operation; 0 means an output (write) operation.
REQ-006 SHALL have ports W7 and Z7, input, 1 each: single-cycle timing strobes marking sequence start and sequence end.
REQ-007 SHALL have port PACK, input, 1: peripheral acknowledge for input operations.
REQ-008 SHALL have port PDATA, input, 26: peripheral read data word.
REQ-009 SHALL have port CHSEL, output, 16: one-hot peripheral channel select.
REQ-010 SHALL have port DOUT_STB, output, 1: single-cycle write strobe.
REQ-011 SHALL have port RDATA, output, 26: captured read word.
REQ-012 SHALL have port RDV, output, 1: single-cycle read-data-valid pulse.
REQ-013 SHALL have port ERR, output, 1: sticky error flag.
REQ-014 SHALL have port BUSY, output, 1: high in every state except IDLE.
REQ-015 SHALL have parameter ACK_TIMEOUT, default 15, 4-bit: maximum number of WAIT_ACK cycles.

Function
REQ-016 SHALL implement states IDLE, SELECT, STROBE, WAIT_ACK, DONE, ABORT.
REQ-017 In IDLE, when W7=1 and PIOD=1 at edge N, SHALL capture {A9D..A1D} into a 9-bit address register, capture DINF, clear ERR, and enter SELECT.
REQ-018 In SELECT, if address[8:4]==0, SHALL drive CHSEL = 1 << address[3:0], registered, valid from cycle N+1, and enter STROBE.
REQ-019 In SELECT, if address[8:4]!=0, SHALL set ERR, keep CHSEL=0, and enter DONE.
REQ-020 In STROBE with captured DINF=0, SHALL pulse DOUT_STB for exactly one cycle (cycle N+2) and enter DONE.
REQ-021 In STROBE with captured DINF=1, SHALL clear the timeout counter and enter WAIT_ACK; no DOUT_STB.
REQ-022 In WAIT_ACK, if PACK=1, SHALL load RDATA<=PDATA on that edge, pulse RDV in the following cycle, and enter DONE.
REQ-023 In WAIT_ACK, if PACK=0, SHALL increment the counter; when the counter reaches ACK_TIMEOUT, SHALL set ERR, load RDATA<=0, skip RDV, and enter DONE.
REQ-024 PACK=1 on the same edge as the counter reaching ACK_TIMEOUT SHALL count as an acknowledge (no ERR).
REQ-025 On entry to DONE, SHALL drive CHSEL to 0; DONE SHALL return to IDLE on Z7=1.
REQ-026 W7 seen in any non-IDLE state SHALL be ignored.
REQ-027 PIOD=0 in SELECT, STROBE or WAIT_ACK SHALL enter ABORT: CHSEL=0, no DOUT_STB or RDV, ERR set; ABORT SHALL return to IDLE on the next edge.
REQ-028 PIOD=0 in DONE SHALL have no effect.
REQ-029 RDATA SHALL hold its value until the next read capture or timeout.
REQ-030 ERR SHALL stay set until the next accepted start (REQ-017).
REQ-031 PACK seen outside WAIT_ACK SHALL be ignored.

Reset
REQ-032 While SIM_RST=1, SHALL force state=IDLE, CHSEL=0, DOUT_STB=0, RDV=0, RDATA=0, ERR=0, BUSY=0, counter=0, address register=0.
REQ-033 SIM_RST asserted mid-operation SHALL cancel the operation immediately, with no pending strobe emitted after release.

Verification
REQ-034 Write: address 0x005, DINF=0, PIOD=1, W7 pulse -> CHSEL=0x0020 from N+1, DOUT_STB=1 only at N+2, CHSEL=0 in DONE, IDLE after Z7.
REQ-035 Read: address 0x00F, DINF=1, PACK asserted 3 cycles after WAIT_ACK entry with PDATA=0x2AAAAAA -> RDATA=0x2AAAAAA, one RDV pulse, ERR=0.
REQ-036 Timeout: read with PACK held 0 -> ERR=1 after 15 WAIT_ACK cycles, RDATA=0, no RDV.
REQ-037 Bad address: address 0x010 -> ERR=1, CHSEL never nonzero, no DOUT_STB.
REQ-038 Abort: PIOD dropped while in WAIT_ACK -> CHSEL=0, ERR=1, no RDV, IDLE two edges later.
REQ-039 Reset mid-read: SIM_RST pulsed while in WAIT_ACK -> all outputs 0 asynchronously, no RDV after release.
